dmem_unit: RTL and testbench

Parametrised, handshaked data-memory unit for the MEM stage. It replaces the single-cycle combinational-read data memory with a synchronous-read, word-organised RAM behind a valid/ready request/response interface. Loads and stores use the existing load/store type encodings. The unit detects out-of-range and illegal accesses and can optionally split misaligned accesses into two word accesses. The MEM stage stalls the pipeline on `req_ready`/`rsp_valid`.

---
 rtl/dmem_pkg.sv | 67 ++++++
 rtl/dmem_ram.sv | 32 +++
 rtl/dmem_unit.sv | 214 +++++++++++++++++++++
 tb/tb_dmem_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory unit: load/store encodings, FSM states,
// access-size decode and the per-size byte-enable patterns.
package dmem_pkg;

    typedef enum logic [2:0] {
        LT_LB  = 3'b000,
        LT_LH  = 3'b001,
        LT_LW  = 3'b010,
        LT_LBU = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_RESP
    } state_e;

    // Byte-enable patterns for a word-aligned access of each size.
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Access size in bytes; 0 marks an illegal type encoding.
    function automatic logic [2:0] access_size(input logic       is_write,
                                               input logic [2:0] load_type,
                                               input logic [1:0] store_type);
        logic [2:0] size;
        size = 3'd0;
        if (is_write) begin
            case (store_type)
                ST_SB:   size = 3'd1;
                ST_SH:   size = 3'd2;
                ST_SW:   size = 3'd4;
                default: size = 3'd0;
            endcase
        end else begin
            case (load_type)
                LT_LB, LT_LBU: size = 3'd1;
                LT_LH, LT_LHU: size = 3'd2;
                LT_LW:         size = 3'd4;
                default:       size = 3'd0;
            endcase
        end
        return size;
    endfunction

    // Byte-enable pattern for a given access size.
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        logic [3:0] mask;
        case (size)
            3'd1:    mask = MASK_B;
            3'd2:    mask = MASK_H;
            3'd4:    mask = MASK_W;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised single-port RAM: byte write enables, one-cycle synchronous read.
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-masked write and registered read of the addressed word.
    // NOTE: the array has no reset so it maps onto RAM macros; sequential state uses <= so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_unit.sv
// MEM-stage data memory behind a valid/ready request/response interface.
// Optional feature macro: DMEM_MISALIGN_SPLIT_EN (misaligned accesses are
// executed, word-crossing ones in two RAM accesses); undefined, every
// misaligned access is rejected with rsp_err.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_load_type,
    input  logic [1:0]        req_store_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e        r_state;
    state_e        w_next;

    // Registered request
    logic          r_write;
    logic [2:0]    r_ltype;
    logic [2:0]    r_size;
    logic [1:0]    r_off;
    logic [AW-1:0] r_word;
    logic [31:0]   r_wdata;
    logic          r_err;
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic          r_split;
    logic [31:0]   r_lo;
    logic          w_cross;
    logic          w_split;
`else
    logic          w_misalign;
`endif

    // Registered response
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    // Request decode
    logic          w_accept;
    logic [2:0]    w_size;
    logic [1:0]    w_off;
    logic [ADDR_W-3:0] w_word_hi;
    logic          w_err;

    // Datapath
    logic [63:0]   w_lanes;
    logic [7:0]    w_mask8;
    logic          w_ram_en;
    logic          w_ram_hi;
    logic [3:0]    w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_rdata;
    logic [31:0]   w_word0;
    logic [31:0]   w_word1;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load;

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_size    = access_size(req_write, req_load_type, req_store_type);
    assign w_off     = req_addr[1:0];
    assign w_word_hi = req_addr[ADDR_W-1:2];

    // Decide rejection (and splitting) of the request on offer.
    always_comb begin
        w_err = (w_size == 3'd0) || (w_word_hi >= (ADDR_W-2)'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_SPLIT_EN
        w_cross = ({1'b0, w_off} + w_size) > 3'd4;
        w_err   = w_err || (w_cross && (w_word_hi[AW-1:0] == AW'(DEPTH_WORDS - 1)));
        w_split = w_cross && !w_err;
`else
        w_misalign = ((w_size == 3'd2) && w_off[0]) || ((w_size == 3'd4) && (w_off != 2'b00));
        w_err      = w_err || w_misalign;
`endif
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next = S_ACC0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            S_ACC0: w_next = r_split ? S_ACC1 : S_RESP;
`else
            S_ACC0: w_next = S_RESP;
`endif
            S_ACC1: w_next = S_RESP;
            S_RESP: if (r_rsp_valid && rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Capture the request at acceptance; the inputs are don't-care afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write <= 1'b0;
            r_ltype <= 3'd0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_word  <= '0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            r_split <= 1'b0;
            r_lo    <= 32'd0;
`endif
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_ltype <= req_load_type;
                r_size  <= w_size;
                r_off   <= w_off;
                r_word  <= w_word_hi[AW-1:0];
                r_wdata <= req_wdata;
                r_err   <= w_err;
`ifdef DMEM_MISALIGN_SPLIT_EN
                r_split <= w_split;
`endif
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            // Lower word of a split load arrives while ACC1 reads the upper one.
            if (r_state == S_ACC1) r_lo <= w_ram_rdata;
`endif
        end
    end

    // Store lanes and byte enables across the two-word window.
    assign w_lanes = {32'd0, r_wdata} << {r_off, 3'b000};
    assign w_mask8 = {4'b0000, size_mask(r_size)} << r_off;

    assign w_ram_hi    = (r_state == S_ACC1);
    assign w_ram_en    = !r_err && ((r_state == S_ACC0) || w_ram_hi);
    assign w_ram_addr  = w_ram_hi ? (r_word + AW'(1)) : r_word;
    assign w_ram_wdata = w_ram_hi ? w_lanes[63:32] : w_lanes[31:0];
    assign w_ram_we    = !r_write ? 4'b0000 : (w_ram_hi ? w_mask8[7:4] : w_mask8[3:0]);

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Align the loaded bytes and extend them to 32 bits.
    always_comb begin
`ifdef DMEM_MISALIGN_SPLIT_EN
        w_word0 = r_split ? r_lo : w_ram_rdata;
        w_word1 = r_split ? w_ram_rdata : 32'd0;
`else
        w_word0 = w_ram_rdata;
        w_word1 = 32'd0;
`endif
        w_shifted = 32'({w_word1, w_word0} >> {r_off, 3'b000});
        case (r_ltype)
            LT_LB:   w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LT_LH:   w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LT_LW:   w_load = w_shifted;
            LT_LBU:  w_load = {24'd0, w_shifted[7:0]};
            LT_LHU:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = 32'd0;
        endcase
        if (r_err || r_write) w_load = 32'd0;
    end

    // Response register: filled on the first RESP cycle, held until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == S_RESP) begin
            if (!r_rsp_valid) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_load;
                r_rsp_err   <= r_err;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: byte-addressed reference memory,
// directed cases pinned to literal values, then randomized traffic.
module tb_dmem_unit;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_load_type = 3'd0;
    logic [1:0]  req_store_type = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          size;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [DEPTH*4];

    dmem_unit #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_load_type  (req_load_type),
        .req_store_type (req_store_type),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: byte-addressed little-endian memory, rules applied directly.
    function automatic exp_t predict(input logic w, input logic [2:0] lt, input logic [1:0] st,
                                     input logic [31:0] addr);
        exp_t        e;
        longint      a;
        int          off;
        bit          sgn;
        logic [31:0] val;
        logic [31:0] ones;
        a    = longint'(addr);
        off  = int'(a % 4);
        sgn  = 1'b0;
        e.size = 0;
        if (w) begin
            case (st)
                2'd0: e.size = 1;
                2'd1: e.size = 2;
                2'd2: e.size = 4;
                default: e.size = 0;
            endcase
        end else begin
            case (lt)
                3'd0: begin e.size = 1; sgn = 1'b1; end
                3'd1: begin e.size = 2; sgn = 1'b1; end
                3'd2: e.size = 4;
                3'd3: e.size = 1;
                3'd4: e.size = 2;
                default: e.size = 0;
            endcase
        end
        e.err = (e.size == 0) || ((a / 4) >= DEPTH) || (a + e.size > DEPTH * 4);
`ifndef DMEM_MISALIGN_SPLIT_EN
        if (e.size != 0 && (a % e.size) != 0) e.err = 1'b1;
`endif
        e.lat   = (!e.err && (off + e.size > 4)) ? 3 : 2;
        e.rdata = 32'd0;
        if (!e.err && !w) begin
            val = 32'd0;
            for (int i = 0; i < e.size; i++) val[8*i +: 8] = mem_m[a + i];
            if (sgn && e.size < 4 && val[8*e.size-1]) begin
                ones = '1;
                val  = val | (ones << (8 * e.size));
            end
            e.rdata = val;
        end
        return e;
    endfunction

    task automatic apply_store(input logic w, input logic [31:0] addr, input logic [31:0] wd, input exp_t e);
        if (w && !e.err) begin
            for (int i = 0; i < e.size; i++) mem_m[longint'(addr) + i] = wd[8*i +: 8];
        end
    endtask

    // Compare process: every cycle a response is shown it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
                check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One request/response transaction; starts and ends 1 time unit after a rising edge.
    task automatic txn(input logic w, input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold);
        exp_t e;
        int   k;
        e = predict(w, lt, st, addr);
        req_valid      = 1'b1;
        req_write      = w;
        req_load_type  = lt;
        req_store_type = st;
        req_addr       = addr;
        req_wdata      = wd;
        rsp_ready      = 1'b0;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        exp_q.push_back(e);
        apply_store(w, addr, wd, e);
        @(posedge clk); #1;
        req_valid      = 1'b0;
        req_write      = 1'($urandom_range(0, 1));
        req_load_type  = 3'($urandom);
        req_store_type = 2'($urandom);
        req_addr       = $urandom;
        req_wdata      = $urandom;
        k = 0;
        while (!rsp_valid && k < 8) begin
            check("req_ready_busy", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, e.lat);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_take", {31'd0, rsp_valid}, 32'd0);
        check("req_ready_after_take", {31'd0, req_ready}, 32'd1);
    endtask

    // Directed transaction with the reference pinned to hand-computed values.
    task automatic dir(input string nm, input logic w, input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold,
                       input logic [31:0] lit_rdata, input logic lit_err, input int lit_lat);
        exp_t e;
        e = predict(w, lt, st, addr);
        check({nm, "_ref_rdata"}, e.rdata, lit_rdata);
        check({nm, "_ref_err"}, {31'd0, e.err}, {31'd0, lit_err});
        check({nm, "_ref_lat"}, e.lat, lit_lat);
        txn(w, lt, st, addr, wd, hold);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  lt;
        logic [1:0]  st;
        int          sel;

        for (int i = 0; i < DEPTH * 4; i++) mem_m[i] = 8'h00;

        #2 rst = 1'b0;
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        #20 rst = 1'b1;
        @(posedge clk); #1;

        // Clear the RAM so it matches the zeroed reference.
        for (int w = 0; w < DEPTH; w++) txn(1'b1, 3'd0, 2'd2, 32'(w * 4), 32'd0, 0);

        dir("sw10",   1'b1, 3'd0, 2'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1'b0, 2);
        dir("lw10",   1'b0, 3'd2, 2'd0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 1'b0, 2);
        dir("sb13",   1'b1, 3'd0, 2'd0, 32'h13, 32'h00000080, 0, 32'h0,        1'b0, 2);
        dir("lb13",   1'b0, 3'd0, 2'd0, 32'h13, 32'h0,        0, 32'hFFFFFF80, 1'b0, 2);
        dir("lbu13",  1'b0, 3'd3, 2'd0, 32'h13, 32'h0,        0, 32'h00000080, 1'b0, 2);
        dir("lw10b",  1'b0, 3'd2, 2'd0, 32'h10, 32'h0,        0, 32'h80ADBEEF, 1'b0, 2);
        dir("sw1c",   1'b1, 3'd0, 2'd2, 32'h1C, 32'hCAFEF00D, 0, 32'h0,        1'b0, 2);
`ifdef DMEM_MISALIGN_SPLIT_EN
        dir("sw1e",   1'b1, 3'd0, 2'd2, 32'h1E, 32'h11223344, 0, 32'h0,        1'b0, 3);
        dir("lw1e",   1'b0, 3'd2, 2'd0, 32'h1E, 32'h0,        0, 32'h11223344, 1'b0, 3);
        dir("lhu20",  1'b0, 3'd4, 2'd0, 32'h20, 32'h0,        0, 32'h00001122, 1'b0, 2);
        dir("lhu1f",  1'b0, 3'd4, 2'd0, 32'h1F, 32'h0,        0, 32'h00002233, 1'b0, 3);
        dir("lh1d",   1'b0, 3'd1, 2'd0, 32'h1D, 32'h0,        0, 32'h000044F0, 1'b0, 2);
        dir("lw1c",   1'b0, 3'd2, 2'd0, 32'h1C, 32'h0,        0, 32'h3344F00D, 1'b0, 2);
        dir("lw_top_x", 1'b0, 3'd2, 2'd0, 32'(DEPTH * 4 - 2), 32'h0, 0, 32'h0, 1'b1, 2);
`else
        dir("sw1e",   1'b1, 3'd0, 2'd2, 32'h1E, 32'h11223344, 0, 32'h0,        1'b1, 2);
        dir("lw1c",   1'b0, 3'd2, 2'd0, 32'h1C, 32'h0,        0, 32'hCAFEF00D, 1'b0, 2);
        dir("lh1d",   1'b0, 3'd1, 2'd0, 32'h1D, 32'h0,        0, 32'h0,        1'b1, 2);
`endif
        dir("lw_oob", 1'b0, 3'd2, 2'd0, 32'(DEPTH * 4), 32'h0, 0, 32'h0,       1'b1, 2);
        dir("lw_big", 1'b0, 3'd2, 2'd0, 32'h8000_0010, 32'h0, 0, 32'h0,        1'b1, 2);
        dir("lt111",  1'b0, 3'd7, 2'd0, 32'h10, 32'h0,        0, 32'h0,        1'b1, 2);
        dir("st11",   1'b1, 3'd0, 2'd3, 32'h10, 32'h12345678, 0, 32'h0,        1'b1, 2);
        dir("lw_hold",1'b0, 3'd2, 2'd0, 32'h10, 32'h0,        5, 32'h80ADBEEF, 1'b0, 2);

        // Reset during ACC0 drops the response immediately.
        req_valid = 1'b1; req_write = 1'b0; req_load_type = 3'd2; req_addr = 32'h10;
        check("rst_pre_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_after_req_ready", {31'd0, req_ready}, 32'd1);
        dir("lw_after_rst", 1'b0, 3'd2, 2'd0, 32'h10, 32'h0, 0, 32'h80ADBEEF, 1'b0, 2);

        // Randomized traffic concentrated on a small window plus the top of memory.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = $urandom;
            else if (sel <= 2) a = 32'(DEPTH * 4 - 8) + 32'($urandom_range(0, 15));
            else               a = 32'($urandom_range(0, 127));
            lt = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            st = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            txn(1'($urandom_range(0, 1)), lt, st, a, $urandom,
                ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2));
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
